// File: rtl/credit_return_unit.sv
// rtl/credit_return_unit.sv - receiver-side credit return with one-sim-cycle latency
// Counts dequeued flits and offers them back upstream after the next sim_time_tick.
module credit_return_unit #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_sim_time_tick,
    input  logic [WIDTH-1:0] i_config_in,
    input  logic             i_config_in_valid,
    output logic [WIDTH-1:0] o_config_out,
    output logic             o_config_out_valid,
    input  logic             i_credit_release,
    output logic             o_credit_out_valid,
    input  logic             i_credit_ack,
    output logic [WIDTH-1:0] o_pending_count,
    output logic             o_error
);

    logic [WIDTH-1:0] r_max_credits;
    logic [WIDTH-1:0] r_cur_cnt;
    logic [WIDTH-1:0] r_ready_cnt;
    logic [WIDTH-1:0] r_config_out;
    logic             r_config_out_valid;
    logic             r_error;

    logic [WIDTH-1:0] w_pending;
    logic [WIDTH-1:0] w_cur_nxt;
    logic [WIDTH-1:0] w_ready_nxt;
    logic             w_ovf;
    logic             w_ack;
    logic             w_rel;
    logic             w_drop;

    assign w_pending          = r_ready_cnt + r_cur_cnt;
    // >= rather than == also guards a depth lowered below the pending count while paused
    assign w_ovf              = (w_pending >= r_max_credits);
    assign o_credit_out_valid = i_enable & (r_ready_cnt != '0);
    assign w_ack              = i_credit_ack & o_credit_out_valid;
    assign w_rel              = i_credit_release & i_enable & ~w_ovf;
    assign w_drop             = i_credit_release & i_enable & w_ovf;

    assign o_pending_count    = w_pending;
    assign o_config_out       = r_config_out;
    assign o_config_out_valid = r_config_out_valid;
    assign o_error            = r_error;

    always_comb begin
        w_cur_nxt   = r_cur_cnt;
        w_ready_nxt = r_ready_cnt;
        if (i_enable) begin
            if (i_sim_time_tick) begin
                // a release on the tick edge belongs to the new simulated cycle
                w_ready_nxt = r_ready_cnt + r_cur_cnt - WIDTH'(w_ack);
                w_cur_nxt   = WIDTH'(w_rel);
            end else begin
                w_ready_nxt = r_ready_cnt - WIDTH'(w_ack);
                w_cur_nxt   = r_cur_cnt + WIDTH'(w_rel);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_max_credits      <= '0;
            r_cur_cnt          <= '0;
            r_ready_cnt        <= '0;
            r_config_out       <= '0;
            r_config_out_valid <= 1'b0;
            r_error            <= 1'b0;
        end else begin
            r_config_out       <= r_max_credits;
            r_config_out_valid <= i_config_in_valid;
            if (i_config_in_valid && !i_enable) begin
                r_max_credits <= i_config_in;
            end
            r_cur_cnt   <= w_cur_nxt;
            r_ready_cnt <= w_ready_nxt;
            if (w_drop) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule
